demux1t8_32_seq: RTL and testbench
==================================

Name: demux1t8_32_seq

Overview:
Registered 1-to-8 word distributor; the write-side counterpart of the 8-to-1 32-bit read mux. It takes one 32-bit input word per write strobe and latches it into one of eight held output channels. Channels are chosen either by an explicit 3-bit select or by an internal round-robin pointer that fills all eight channels as a frame. Typical consumers are display and LED banks on the Nexys4 board that read the eight held words in parallel.

Parameters:
WIDTH, 32, data width of din and each output channel
RST_VAL, 0, value loaded into every channel on rst or clr
AUTO_REARM, 1, 1 = sequential mode restarts at channel 0 after a frame; 0 = block holds after a frame until rearm

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
mode  input  1  0 = addressed (use s), 1 = sequential (use internal pointer)
we  input  1  write strobe; a word is accepted when we && ready at a rising edge
s  input  3  channel select in addressed mode; ignored in sequential mode
din  input  WIDTH  write data
clr  input  1  synchronous clear of all channels; does not touch the FSM
rearm  input  1  releases HOLD state (AUTO_REARM=0 only)
ready  output  1  1 = block accepts a write this cycle
o0..o7  output  WIDTH each  held channel values
upd  output  8  one-hot, one-cycle pulse marking the channel written on the previous edge
wr_ptr  output  3  current sequential pointer
frame_done  output  1  one-cycle pulse after channel 7 is written in sequential mode

Behaviour:
- Reset (rst=1 at edge): o0..o7=RST_VAL, upd=0, frame_done=0, wr_ptr=0, FSM=RUN, ready=1. Reset has priority over every other input.
- Priority at an edge: rst > clr > write.
- clr: all channels = RST_VAL, upd=0. wr_ptr and the FSM are unchanged. A write in the same cycle is discarded.
- Accepted write: we && ready && !clr.
- Write latency: the channel register updates at the accepting edge and is visible the following cycle. upd bit is high for exactly that one cycle. Channels not written hold their value.
- Addressed mode (mode=0):
  - target = s; wr_ptr unchanged; frame_done never asserts.
  - Back-to-back writes to the same channel are allowed every cycle; the last write wins.
- Sequential mode (mode=1):
  - target = wr_ptr; wr_ptr increments by 1 modulo 8 on each accepted write.
  - Writing channel 7 asserts frame_done for one cycle, aligned with upd[7].
- FSM has two states, RUN and HOLD. ready = (state==RUN).
  - RUN -> HOLD: on a channel-7 sequential write when AUTO_REARM=0.
  - HOLD -> RUN: on rearm=1; wr_ptr is already 0. Writes arriving while in HOLD are ignored: no channel change, no upd.
  - With AUTO_REARM=1 the block never enters HOLD and wr_ptr simply wraps 7->0.
- Mode change: the block registers mode. Any edge where mode differs from its registered value sets wr_ptr=0 and FSM=RUN. A write in that same cycle is still accepted using the new mode; in sequential mode it goes to channel 0 and the pointer becomes 1.
- rearm in RUN state has no effect. rearm and we together in HOLD: the state returns to RUN but the write is not accepted.

Test Plan:
- Reset: drive rst=1 with we=1, din=32'hDEADBEEF -> after release, all o = 0, upd=0, wr_ptr=0, ready=1.
- Addressed writes: mode=0; write s=5 din=32'h12345678, then s=0 din=32'hA5A5A5A5 -> o5=12345678, o0=A5A5A5A5, others 0; upd=8'h20 then 8'h01 on consecutive cycles; frame_done stays 0.
- Sequential frame, AUTO_REARM=1: mode=1; 10 consecutive writes of din=1..10 -> o0..o7 = 9,10,3,4,5,6,7,8; frame_done pulses once after the 8th write; wr_ptr=2 at the end.
- HOLD handshake, AUTO_REARM=0: 8 sequential writes -> ready=0; a 9th write of 32'hFFFF is ignored (o0 unchanged, upd=0); after a rearm pulse ready=1 and the next write lands in o0.
- Mode switch mid-frame: 3 sequential writes, then toggle mode to 0 and back to 1 -> wr_ptr=0; the next sequential write lands in o0.
- clr vs write same cycle: clr=1 with we=1, s=3, din=7 -> all o=0, upd=0; wr_ptr unchanged from its prior value.

Source files
------------

// File: rtl/demux1t8_32_seq.sv
// Registered 1-to-8 word distributor.
// Each accepted write latches din into one of eight held output channels. The
// channel comes from s in addressed mode (mode=0) or from an internal
// round-robin pointer in sequential mode (mode=1), which fills channels 0..7 as
// a frame.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (highest priority)
//   mode       0 = addressed (s), 1 = sequential (wr_ptr)
//   we         write strobe, accepted when we && ready && !clr
//   s          channel select in addressed mode
//   din        write data
//   clr        synchronous clear of all channels; FSM and pointer untouched
//   rearm      releases HOLD (AUTO_REARM=0 only)
//   ready      1 when a write can be accepted
//   o0..o7     held channel values
//   upd        one-hot pulse for the channel written on the previous edge
//   wr_ptr     sequential pointer
//   frame_done pulse after channel 7 is written in sequential mode
module demux1t8_32_seq #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter bit               AUTO_REARM = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             we,
    input  logic [2:0]       s,
    input  logic [WIDTH-1:0] din,
    input  logic             clr,
    input  logic             rearm,
    output logic             ready,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic [WIDTH-1:0] o4,
    output logic [WIDTH-1:0] o5,
    output logic [WIDTH-1:0] o6,
    output logic [WIDTH-1:0] o7,
    output logic [7:0]       upd,
    output logic [2:0]       wr_ptr,
    output logic             frame_done
);

    typedef enum logic {StRun, StHold} state_e;

    state_e           state_q, state_d;
    logic             mode_q;
    logic [2:0]       ptr_q, ptr_d;
    logic [7:0]       upd_q, upd_d;
    logic             fd_q, fd_d;
    logic [WIDTH-1:0] ch_q [8];
    logic [WIDTH-1:0] ch_d [8];

    logic             mode_chg;
    logic [2:0]       ptr_base;
    state_e           state_base;
    logic             accept;
    logic [2:0]       target;

    always_comb begin
        // A mode change restarts the frame before this edge's write is routed.
        mode_chg   = (mode != mode_q);
        ptr_base   = mode_chg ? 3'd0 : ptr_q;
        state_base = mode_chg ? StRun : state_q;
        accept     = we && (state_q == StRun) && !clr;
        target     = mode ? ptr_base : s;

        ch_d    = ch_q;
        ptr_d   = ptr_base;
        state_d = state_base;
        upd_d   = 8'd0;
        fd_d    = 1'b0;

        // Writes in HOLD are never accepted, so rearm only needs to flip state.
        if (state_base == StHold && rearm) begin
            state_d = StRun;
        end

        if (clr) begin
            for (int i = 0; i < 8; i++) begin
                ch_d[i] = RST_VAL;
            end
        end else if (accept) begin
            ch_d[target]  = din;
            upd_d[target] = 1'b1;
            if (mode) begin
                ptr_d = ptr_base + 3'd1;
                if (ptr_base == 3'd7) begin
                    fd_d = 1'b1;
                    if (!AUTO_REARM) begin
                        state_d = StHold;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            mode_q  <= 1'b0;
            ptr_q   <= 3'd0;
            upd_q   <= 8'd0;
            fd_q    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                ch_q[i] <= RST_VAL;
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode;
            ptr_q   <= ptr_d;
            upd_q   <= upd_d;
            fd_q    <= fd_d;
            for (int i = 0; i < 8; i++) begin
                ch_q[i] <= ch_d[i];
            end
        end
    end

    assign ready      = (state_q == StRun);
    assign upd        = upd_q;
    assign wr_ptr     = ptr_q;
    assign frame_done = fd_q;
    assign o0         = ch_q[0];
    assign o1         = ch_q[1];
    assign o2         = ch_q[2];
    assign o3         = ch_q[3];
    assign o4         = ch_q[4];
    assign o5         = ch_q[5];
    assign o6         = ch_q[6];
    assign o7         = ch_q[7];

endmodule

// File: tb/tb_demux1t8_32_seq.sv
module tb_demux1t8_32_seq;

    logic        clk = 1'b0;
    logic        rst, mode, we, clr, rearm;
    logic [2:0]  s;
    logic [31:0] din;

    logic        a_ready, a_fd, h_ready, h_fd;
    logic [7:0]  a_upd, h_upd;
    logic [2:0]  a_ptr, h_ptr;
    logic [31:0] a_o [8];
    logic [31:0] h_o [8];

    int checks = 0;
    int errors = 0;

    // Reference model of the AUTO_REARM=1 instance.
    logic [31:0] m_ch [8];
    logic [2:0]  m_ptr;
    logic        m_mode;
    logic [7:0]  m_upd;
    logic        m_fd;

    always #5 clk = ~clk;

    demux1t8_32_seq #(.WIDTH(32), .RST_VAL(32'd0), .AUTO_REARM(1'b1)) u_auto (
        .clk(clk), .rst(rst), .mode(mode), .we(we), .s(s), .din(din), .clr(clr),
        .rearm(rearm), .ready(a_ready),
        .o0(a_o[0]), .o1(a_o[1]), .o2(a_o[2]), .o3(a_o[3]),
        .o4(a_o[4]), .o5(a_o[5]), .o6(a_o[6]), .o7(a_o[7]),
        .upd(a_upd), .wr_ptr(a_ptr), .frame_done(a_fd)
    );

    demux1t8_32_seq #(.WIDTH(32), .RST_VAL(32'd0), .AUTO_REARM(1'b0)) u_hold (
        .clk(clk), .rst(rst), .mode(mode), .we(we), .s(s), .din(din), .clr(clr),
        .rearm(rearm), .ready(h_ready),
        .o0(h_o[0]), .o1(h_o[1]), .o2(h_o[2]), .o3(h_o[3]),
        .o4(h_o[4]), .o5(h_o[5]), .o6(h_o[6]), .o7(h_o[7]),
        .upd(h_upd), .wr_ptr(h_ptr), .frame_done(h_fd)
    );

    // Apply the behavioural rules for one rising edge with the current inputs.
    task automatic model_edge();
        int tgt;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_ch[i] = 32'd0;
            m_ptr = 3'd0; m_mode = 1'b0; m_upd = 8'd0; m_fd = 1'b0;
        end else begin
            if (mode != m_mode) m_ptr = 3'd0;
            m_mode = mode;
            m_upd  = 8'd0;
            m_fd   = 1'b0;
            if (clr) begin
                for (int i = 0; i < 8; i++) m_ch[i] = 32'd0;
            end else if (we) begin
                tgt = mode ? int'(m_ptr) : int'(s);
                m_ch[tgt] = din;
                m_upd = 8'(1 << tgt);
                if (mode) begin
                    m_fd  = (tgt == 7);
                    m_ptr = 3'((int'(m_ptr) + 1) % 8);
                end
            end
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; clr = 1'b0; rearm = 1'b0; rst = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; we = 1'b0; clr = 1'b0; rearm = 1'b0; mode = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b1; din = 32'hDEADBEEF; mode = 1'b0; s = 3'd2;
        clr = 1'b0; rearm = 1'b0;
        cyc(); cyc();
        idle();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_o[i] !== 32'd0 || h_o[i] !== 32'd0) begin
                errors++;
                $display("FAIL reset_o%0d got %h/%h want 0", i, a_o[i], h_o[i]);
            end
        end
        checks++;
        if (a_upd !== 8'd0 || a_ptr !== 3'd0 || a_ready !== 1'b1 || a_fd !== 1'b0 ||
            h_upd !== 8'd0 || h_ptr !== 3'd0 || h_ready !== 1'b1 || h_fd !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got upd=%h ptr=%0d rdy=%b fd=%b want 0 0 1 0",
                     a_upd, a_ptr, a_ready, a_fd);
        end
    endtask

    task automatic test_addressed();
        do_reset();
        mode = 1'b0; we = 1'b1; s = 3'd5; din = 32'h12345678;
        cyc();
        checks++;
        if (a_upd !== 8'h20 || a_fd !== 1'b0) begin
            errors++;
            $display("FAIL addr_upd1 got upd=%h fd=%b want 20 0", a_upd, a_fd);
        end
        s = 3'd0; din = 32'hA5A5A5A5;
        cyc();
        checks++;
        if (a_upd !== 8'h01 || a_fd !== 1'b0) begin
            errors++;
            $display("FAIL addr_upd2 got upd=%h fd=%b want 01 0", a_upd, a_fd);
        end
        idle();
        cyc();
        checks++;
        if (a_o[5] !== 32'h12345678 || a_o[0] !== 32'hA5A5A5A5 || a_upd !== 8'd0 ||
            a_ptr !== 3'd0) begin
            errors++;
            $display("FAIL addr_data got o5=%h o0=%h upd=%h ptr=%0d want 12345678 a5a5a5a5 0 0",
                     a_o[5], a_o[0], a_upd, a_ptr);
        end
        for (int i = 1; i < 8; i++) begin
            if (i == 5) continue;
            checks++;
            if (a_o[i] !== 32'd0) begin
                errors++;
                $display("FAIL addr_other o%0d got %h want 0", i, a_o[i]);
            end
        end
    endtask

    task automatic test_sequential();
        int fd_cnt = 0;
        logic [31:0] want [8] = '{32'd9, 32'd10, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        do_reset();
        mode = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            we = 1'b1; din = 32'(i);
            cyc();
            if (a_fd) fd_cnt++;
            if (i == 8) begin
                checks++;
                if (a_fd !== 1'b1 || a_upd !== 8'h80) begin
                    errors++;
                    $display("FAIL seq_frame_done got fd=%b upd=%h want 1 80", a_fd, a_upd);
                end
            end
        end
        idle();
        cyc();
        checks++;
        if (fd_cnt != 1 || a_ptr !== 3'd2) begin
            errors++;
            $display("FAIL seq_end got fd_cnt=%0d ptr=%0d want 1 2", fd_cnt, a_ptr);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_o[i] !== want[i]) begin
                errors++;
                $display("FAIL seq_o%0d got %h want %h", i, a_o[i], want[i]);
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        mode = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            we = 1'b1; din = 32'(i);
            cyc();
        end
        checks++;
        if (h_ready !== 1'b0 || h_fd !== 1'b1 || h_ptr !== 3'd0) begin
            errors++;
            $display("FAIL hold_enter got rdy=%b fd=%b ptr=%0d want 0 1 0", h_ready, h_fd, h_ptr);
        end
        din = 32'hFFFF;
        cyc();
        checks++;
        if (h_o[0] !== 32'd1 || h_upd !== 8'd0 || h_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_ignore got o0=%h upd=%h rdy=%b want 1 0 0", h_o[0], h_upd, h_ready);
        end
        // rearm together with we: state returns to RUN, write still dropped
        rearm = 1'b1; din = 32'hBAD0;
        cyc();
        idle();
        checks++;
        if (h_ready !== 1'b1 || h_upd !== 8'd0 || h_o[0] !== 32'd1 || h_ptr !== 3'd0) begin
            errors++;
            $display("FAIL hold_rearm got rdy=%b upd=%h o0=%h ptr=%0d want 1 0 1 0",
                     h_ready, h_upd, h_o[0], h_ptr);
        end
        we = 1'b1; din = 32'h55;
        cyc();
        idle();
        checks++;
        if (h_o[0] !== 32'h55 || h_upd !== 8'h01 || h_ptr !== 3'd1) begin
            errors++;
            $display("FAIL hold_resume got o0=%h upd=%h ptr=%0d want 55 01 1", h_o[0], h_upd, h_ptr);
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; din = 32'(100 + i);
            cyc();
        end
        idle();
        mode = 1'b0;
        cyc();
        mode = 1'b1;
        cyc();
        checks++;
        if (a_ptr !== 3'd0) begin
            errors++;
            $display("FAIL mode_ptr got %0d want 0", a_ptr);
        end
        we = 1'b1; din = 32'h77;
        cyc();
        idle();
        checks++;
        if (a_o[0] !== 32'h77 || a_upd !== 8'h01 || a_ptr !== 3'd1) begin
            errors++;
            $display("FAIL mode_write got o0=%h upd=%h ptr=%0d want 77 01 1", a_o[0], a_upd, a_ptr);
        end
    endtask

    task automatic test_clr();
        clr = 1'b1; we = 1'b1; s = 3'd3; din = 32'd7;
        cyc();
        idle();
        checks++;
        if (a_upd !== 8'd0 || a_ptr !== 3'd1) begin
            errors++;
            $display("FAIL clr_ctl got upd=%h ptr=%0d want 0 1", a_upd, a_ptr);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_o[i] !== 32'd0) begin
                errors++;
                $display("FAIL clr_o%0d got %h want 0", i, a_o[i]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst   = ($urandom_range(0, 99) == 0);
            clr   = ($urandom_range(0, 19) == 0);
            we    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            s     = 3'($urandom);
            din   = $urandom;
            rearm = $urandom_range(0, 1);
            cyc();
            checks++;
            if (a_upd !== m_upd || a_fd !== m_fd || a_ptr !== m_ptr || a_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_ctl n=%0d got upd=%h fd=%b ptr=%0d rdy=%b want %h %b %0d 1",
                         n, a_upd, a_fd, a_ptr, a_ready, m_upd, m_fd, m_ptr);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (a_o[i] !== m_ch[i]) begin
                    errors++;
                    $display("FAIL rand_o%0d n=%0d got %h want %h", i, n, a_o[i], m_ch[i]);
                end
            end
        end
        idle();
    endtask

    initial begin
        rst = 1'b0; mode = 1'b0; we = 1'b0; s = 3'd0; din = 32'd0; clr = 1'b0; rearm = 1'b0;
        test_reset();
        test_addressed();
        test_sequential();
        test_hold();
        test_mode_switch();
        test_clr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
